serial_subtractor: RTL and testbench

//   Bit-serial WIDTH-bit subtractor: Diff = A - B - Bin, borrow out on Bout.

---
 rtl/serial_subtractor_if.sv | 23 ++
 rtl/serial_subtractor.sv | 123 ++++++++++++
 tb/tb_serial_subtractor.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/serial_subtractor_if.sv
// rtl/serial_subtractor_if.sv - request/result bundle for the bit-serial subtractor
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Diff;
  logic             Bout;

  modport master (
    output start, A, B, Bin,
    input  busy, done, Diff, Bout
  );

  modport slave (
    input  start, A, B, Bin,
    output busy, done, Diff, Bout
  );
endinterface

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial A - B - Bin, one full-subtractor cell, LSB first
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_subtractor_if.slave  bus
);

  localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic             load;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res;
  logic             borrow;
  logic [CW-1:0]    count;
  logic             a_bit;
  logic             b_bit;
  logic             d_bit;
  logic             borrow_nxt;
  logic             last;
  logic [WIDTH-1:0] res_nxt;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] diff_q;
  logic             bout_q;

  // Single full-subtractor cell on the current LSBs; res_nxt is the result
  // register after this bit shifts in at the top.
  always_comb begin
    a_bit      = a_sh[0];
    b_bit      = b_sh[0];
    d_bit      = a_bit ^ b_bit ^ borrow;
    borrow_nxt = (~a_bit & b_bit) | (~a_bit & borrow) | (b_bit & borrow);
    last       = (count == LAST);
    res_nxt    = {d_bit, res[WIDTH-1:1]};
  end

  // Next-state logic; a start in DONE is accepted just like in IDLE so that
  // back-to-back operations lose no cycle.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (last) state_nxt = DONE;
      end
      DONE: begin
        if (bus.start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Operand shift registers, borrow and bit counter; Diff/Bout update only
  // on the final bit so they hold the last result through IDLE and RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res    <= '0;
      borrow <= 1'b0;
      count  <= '0;
      diff_q <= '0;
      bout_q <= 1'b0;
    end else if (load) begin
      a_sh   <= bus.A;
      b_sh   <= bus.B;
      borrow <= bus.Bin;
      count  <= '0;
    end else if (state == RUN) begin
      a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
      b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
      res    <= res_nxt;
      borrow <= borrow_nxt;
      count  <= count + 1'b1;
      if (last) begin
        diff_q <= res_nxt;
        bout_q <= borrow_nxt;
      end
    end
  end

  // Status flags registered from the next state so they line up with RUN/DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      busy_q <= (state_nxt == RUN);
      done_q <= (state_nxt == DONE);
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.Diff = diff_q;
  assign bus.Bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - scoreboard bench for serial_subtractor
module tb_serial_subtractor;
  parameter int WIDTH = 8;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  serial_subtractor_if #(.WIDTH(WIDTH)) bus ();

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [WIDTH:0] ref_sub(input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b,
                                             input logic bi);
    logic [WIDTH:0] r;
    r = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, bi};
    return r;
  endfunction

  // Reference model: tracks acceptance and completion timing, pushes the
  // expected result on acceptance and pops it on the completing edge.
  logic [WIDTH:0] sb[$];
  int             m_rem;
  logic           m_done;
  logic [WIDTH:0] m_hold;
  int             m_underflow;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rem  = 0;
      m_done = 1'b0;
      m_hold = '0;
      sb.delete();
    end else begin
      logic accept;
      accept = (m_rem == 0) && bus.start;
      if (m_rem > 0) begin
        m_rem--;
        m_done = (m_rem == 0);
        if (m_done) begin
          if (sb.size() == 0) m_underflow++;
          else                m_hold = sb.pop_front();
        end
      end else begin
        m_done = 1'b0;
      end
      if (accept) begin
        sb.push_back(ref_sub(bus.A, bus.B, bus.Bin));
        m_rem = WIDTH;
      end
    end
  end

  // Output monitor on the falling edge.
  int done_cnt;
  int busy_cnt;
  always @(negedge clk) begin
    if (rst_n) begin
      check("busy", 64'(bus.busy), 64'(m_rem > 0));
      check("done", 64'(bus.done), 64'(m_done));
      check("result", 64'({bus.Bout, bus.Diff}), 64'(m_hold));
      if (bus.busy) busy_cnt++;
      if (bus.done) done_cnt++;
    end
  end

  task automatic start_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic bi);
    @(negedge clk);
    bus.start = 1'b1;
    bus.A     = a;
    bus.B     = b;
    bus.Bin   = bi;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int d0);
    int n;
    n = 0;
    while (done_cnt == d0 && n < 4 * WIDTH + 20) begin
      @(negedge clk);
      n++;
    end
    check("done_timeout", 64'(done_cnt != d0), 64'd1);
  endtask

  initial begin
    int d0;
    int b0;
    int n;
    checks      = 0;
    failures    = 0;
    done_cnt    = 0;
    busy_cnt    = 0;
    m_underflow = 0;
    bus.start   = 1'b0;
    bus.A       = '0;
    bus.B       = '0;
    bus.Bin     = 1'b0;
    rst_n       = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_diff", 64'(bus.Diff), 64'd0);
    check("rst_bout", 64'(bus.Bout), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic subtraction with busy duration.
    d0 = done_cnt;
    b0 = busy_cnt;
    start_op(WIDTH'(100), WIDTH'(37), 1'b0);
    wait_done(d0);
    check("busy_cycles", 64'(busy_cnt - b0), 64'(WIDTH));
    check("diff_100_37", 64'({bus.Bout, bus.Diff}), 64'(ref_sub(WIDTH'(100), WIDTH'(37), 1'b0)));

    // Borrow and wrap corners.
    d0 = done_cnt;
    start_op(WIDTH'(5), WIDTH'(10), 1'b0);
    wait_done(d0);
    check("bout_5_10", 64'(bus.Bout), 64'd1);
    d0 = done_cnt;
    start_op('0, '0, 1'b1);
    wait_done(d0);
    check("zero_bin", 64'({bus.Bout, bus.Diff}), {{(63 - WIDTH){1'b0}}, {(WIDTH + 1){1'b1}}});
    d0 = done_cnt;
    start_op('1, '1, 1'b0);
    wait_done(d0);
    check("ones_ones", 64'({bus.Bout, bus.Diff}), 64'd0);

    // Start pulse during RUN must be ignored.
    d0 = done_cnt;
    start_op(WIDTH'(3), WIDTH'(1), 1'b0);
    repeat (2) @(negedge clk);
    bus.start = 1'b1;
    bus.A     = WIDTH'(1);
    bus.B     = WIDTH'(1);
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(d0);
    repeat (WIDTH + 3) @(negedge clk);
    check("one_done_pulse", 64'(done_cnt - d0), 64'd1);
    check("ignored_result", 64'({bus.Bout, bus.Diff}), 64'(ref_sub(WIDTH'(3), WIDTH'(1), 1'b0)));

    // Reset in the 4th RUN cycle aborts the operation.
    start_op(WIDTH'(9), WIDTH'(2), 1'b1);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_done", 64'(bus.done), 64'd0);
    check("abort_diff", 64'(bus.Diff), 64'd0);
    check("abort_bout", 64'(bus.Bout), 64'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    d0 = done_cnt;
    repeat (2 * WIDTH + 2) @(negedge clk);
    check("no_done_after_abort", 64'(done_cnt - d0), 64'd0);

    // Back-to-back with start held high and random operands every cycle.
    d0 = done_cnt;
    n  = 0;
    while ((done_cnt - d0) < 1200 && n < 1200 * (WIDTH + 1) + 50) begin
      bus.start = 1'b1;
      bus.A     = WIDTH'($urandom);
      bus.B     = WIDTH'($urandom);
      bus.Bin   = 1'($urandom_range(0, 1));
      @(negedge clk);
      n++;
    end
    bus.start = 1'b0;
    check("b2b_count", 64'(done_cnt - d0), 64'd1200);
    check("b2b_period", 64'(n), 64'(1200 * (WIDTH + 1) + 1));

    // Drain and make sure nothing was left over.
    repeat (WIDTH + 4) @(negedge clk);
    check("sb_empty", 64'(sb.size()), 64'd0);
    check("sb_underflow", 64'(m_underflow), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
